// File: rtl/tomasulo_pkg.sv
// ---------------------------------------------------------------------------
// tomasulo_pkg
// Shared types and constants for the Tomasulo issue slice.
//   PKG_ROB_DEPTH : reorder-buffer depth the tag width is sized for
//   TAG_W         : ROB tag width, $clog2 of the ROB depth
//   XLEN          : datapath width
//   FUNCT_*       : internal R-type function codes produced by the decoder
//   src_operand_t : renamed source operand {rdy, tag, value}
// ---------------------------------------------------------------------------
package tomasulo_pkg;

  localparam int PKG_ROB_DEPTH = 16;
  localparam int TAG_W         = $clog2(PKG_ROB_DEPTH);
  localparam int XLEN          = 32;
  localparam int NUM_ARCH_REGS = 32;

  // Internal function codes, contiguous from ADD to AND.
  localparam logic [5:0] FUNCT_ADD  = 6'b011011;
  localparam logic [5:0] FUNCT_SUB  = 6'b011100;
  localparam logic [5:0] FUNCT_SLL  = 6'b011101;
  localparam logic [5:0] FUNCT_SLT  = 6'b011110;
  localparam logic [5:0] FUNCT_SLTU = 6'b011111;
  localparam logic [5:0] FUNCT_XOR  = 6'b100000;
  localparam logic [5:0] FUNCT_SRL  = 6'b100001;
  localparam logic [5:0] FUNCT_SRA  = 6'b100010;
  localparam logic [5:0] FUNCT_OR   = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;

  // A source is either ready with its value, or waiting on a ROB tag.
  typedef struct packed {
    logic              rdy;
    logic [TAG_W-1:0]  tag;
    logic [XLEN-1:0]   value;
  } src_operand_t;

endpackage

// File: rtl/rat_table.sv
// ---------------------------------------------------------------------------
// rat_table
// Register alias table: 32 entries of {valid, tag}. valid=1 means the
// architectural register file holds the newest value; valid=0 means the
// value is still being produced by the ROB entry named by tag.
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   flush                 : synchronous, marks every entry valid
//   rd_addr1/2            : combinational lookup addresses
//   rd_valid1/2, rd_tag1/2: lookup results (pre-update mapping)
//   ren_en/addr/tag       : rename port, maps addr to a fresh ROB tag
//   cmt_en/addr/tag       : commit port, revalidates addr if tag still owns it
// ---------------------------------------------------------------------------
module rat_table
  import tomasulo_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [4:0]       rd_addr1,
  input  logic [4:0]       rd_addr2,
  output logic             rd_valid1,
  output logic             rd_valid2,
  output logic [TAG_W-1:0] rd_tag1,
  output logic [TAG_W-1:0] rd_tag2,
  input  logic             ren_en,
  input  logic [4:0]       ren_addr,
  input  logic [TAG_W-1:0] ren_tag,
  input  logic             cmt_en,
  input  logic [4:0]       cmt_addr,
  input  logic [TAG_W-1:0] cmt_tag
);

  logic [NUM_ARCH_REGS-1:0] valid_q;
  logic [TAG_W-1:0]         tag_q [NUM_ARCH_REGS];

  assign rd_valid1 = valid_q[rd_addr1];
  assign rd_valid2 = valid_q[rd_addr2];
  assign rd_tag1   = tag_q[rd_addr1];
  assign rd_tag2   = tag_q[rd_addr2];

  // Commit only revalidates an entry whose mapping still belongs to the
  // retiring tag; a younger rename of the same register keeps it pending.
  // The rename assignment comes last so it overrides a same-cycle commit
  // to the same register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '1;
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
        tag_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '1;
    end else begin
      if (cmt_en && !valid_q[cmt_addr] && (tag_q[cmt_addr] == cmt_tag)) begin
        valid_q[cmt_addr] <= 1'b1;
      end
      if (ren_en) begin
        valid_q[ren_addr] <= 1'b0;
        tag_q[ren_addr]   <= ren_tag;
      end
    end
  end

endmodule

// File: rtl/issue_unit.sv
// ---------------------------------------------------------------------------
// issue_unit
// Issue stage of a Tomasulo core for R-type instructions. Accepts one
// decoded instruction per cycle, picks a free reservation station, allocates
// a ROB tag, renames sources through the RAT (with CDB bypass) and presents
// the complete RS+ROB payload one cycle after acceptance.
// Ports:
//   clock, reset                       : clock, asynchronous active-high reset
//   dec_valid/dec_ready                : decode handshake
//   dec_funct, dec_rd, dec_rs1, dec_rs2: decoded instruction fields
//   rs_busy                            : busy bits of the RS array
//   rf_raddr1/2, rf_rdata1/2           : combinational register-file read
//   cdb_valid/tag/value                : common data bus broadcast
//   commit_valid/tag/rd                : ROB head retirement
//   flush                              : synchronous pipeline flush
//   alloc_*                            : registered allocation strobe+payload
// The ROB tag width comes from the package, so ROB_DEPTH may be any power
// of two up to PKG_ROB_DEPTH without touching the package.
// ---------------------------------------------------------------------------
module issue_unit
  import tomasulo_pkg::*;
#(
  parameter int NUM_RS    = 4,
  parameter int ROB_DEPTH = PKG_ROB_DEPTH,
  parameter int IDX_W     = 11
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               dec_valid,
  output logic               dec_ready,
  input  logic [5:0]         dec_funct,
  input  logic [4:0]         dec_rd,
  input  logic [4:0]         dec_rs1,
  input  logic [4:0]         dec_rs2,
  input  logic [NUM_RS-1:0]  rs_busy,
  output logic [4:0]         rf_raddr1,
  output logic [4:0]         rf_raddr2,
  input  logic [XLEN-1:0]    rf_rdata1,
  input  logic [XLEN-1:0]    rf_rdata2,
  input  logic               cdb_valid,
  input  logic [TAG_W-1:0]   cdb_tag,
  input  logic [XLEN-1:0]    cdb_value,
  input  logic               commit_valid,
  input  logic [TAG_W-1:0]   commit_tag,
  input  logic [4:0]         commit_rd,
  input  logic               flush,
  output logic               alloc_valid,
  output logic [NUM_RS-1:0]  alloc_rs_sel,
  output logic [5:0]         alloc_funct,
  output logic [TAG_W-1:0]   alloc_tag,
  output logic [4:0]         alloc_rd,
  output logic [IDX_W-1:0]   alloc_index,
  output src_operand_t       alloc_src1,
  output src_operand_t       alloc_src2
);

  localparam int CNT_W = $clog2(ROB_DEPTH + 1);

  logic [CNT_W-1:0]  rob_count;
  logic [TAG_W-1:0]  rob_tail;
  logic [IDX_W-1:0]  issue_idx;
  logic              alloc_valid_q;
  logic              rob_full;
  logic              accept;
  logic [NUM_RS-1:0] pend_mask;
  logic [NUM_RS-1:0] free_mask;
  logic [NUM_RS-1:0] sel_onehot;
  logic              sel_found;
  logic              rat_valid1;
  logic              rat_valid2;
  logic [TAG_W-1:0]  rat_tag1;
  logic [TAG_W-1:0]  rat_tag2;
  src_operand_t      src1_next;
  src_operand_t      src2_next;

  // Source renaming: x0 is hard zero, a valid RAT entry reads the register
  // file, a pending one waits on its tag unless the CDB delivers that tag
  // in this very cycle. Ready operands carry tag 0.
  function automatic src_operand_t resolve_src(
    input logic [4:0]       addr,
    input logic             map_valid,
    input logic [TAG_W-1:0] map_tag,
    input logic [XLEN-1:0]  rf_data,
    input logic             bus_valid,
    input logic [TAG_W-1:0] bus_tag,
    input logic [XLEN-1:0]  bus_value
  );
    src_operand_t s;
    s = '0;
    if (addr == 5'd0) begin
      s.rdy = 1'b1;
    end else if (map_valid) begin
      s.rdy   = 1'b1;
      s.value = rf_data;
    end else if (bus_valid && (bus_tag == map_tag)) begin
      s.rdy   = 1'b1;
      s.value = bus_value;
    end else begin
      s.tag = map_tag;
    end
    return s;
  endfunction

  assign rf_raddr1 = dec_rs1;
  assign rf_raddr2 = dec_rs2;

  // The entry handed out last cycle is not yet visible in rs_busy, so it is
  // masked for exactly the cycle the allocation strobe is on the bus.
  assign pend_mask = alloc_valid_q ? alloc_rs_sel : '0;
  assign rob_full  = (rob_count == CNT_W'(ROB_DEPTH));
  assign dec_ready = !rob_full && (free_mask != '0) && !flush;
  assign accept    = dec_valid && dec_ready;

  // A flush in the strobe cycle cancels the allocation in flight.
  assign alloc_valid = alloc_valid_q && !flush;

  // Lowest-numbered free reservation station, as a one-hot select.
  always_comb begin
    free_mask  = ~(rs_busy | pend_mask);
    sel_onehot = '0;
    sel_found  = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (free_mask[i] && !sel_found) begin
        sel_onehot[i] = 1'b1;
        sel_found     = 1'b1;
      end
    end
  end

  // Operand lookup against the mapping as it stands before this cycle's
  // rename, so an instruction reading its own destination sees the old tag.
  always_comb begin
    src1_next = resolve_src(dec_rs1, rat_valid1, rat_tag1, rf_rdata1,
                            cdb_valid, cdb_tag, cdb_value);
    src2_next = resolve_src(dec_rs2, rat_valid2, rat_tag2, rf_rdata2,
                            cdb_valid, cdb_tag, cdb_value);
  end

  rat_table u_rat (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .rd_addr1  (dec_rs1),
    .rd_addr2  (dec_rs2),
    .rd_valid1 (rat_valid1),
    .rd_valid2 (rat_valid2),
    .rd_tag1   (rat_tag1),
    .rd_tag2   (rat_tag2),
    .ren_en    (accept && (dec_rd != 5'd0)),
    .ren_addr  (dec_rd),
    .ren_tag   (rob_tail),
    .cmt_en    (commit_valid),
    .cmt_addr  (commit_rd),
    .cmt_tag   (commit_tag)
  );

  // Allocation payload register. The strobe follows accept by one cycle;
  // the payload holds its last value while the strobe is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alloc_valid_q <= 1'b0;
      alloc_rs_sel  <= '0;
      alloc_funct   <= '0;
      alloc_tag     <= '0;
      alloc_rd      <= '0;
      alloc_index   <= '0;
      alloc_src1    <= '0;
      alloc_src2    <= '0;
    end else begin
      alloc_valid_q <= accept;
      if (accept) begin
        alloc_rs_sel <= sel_onehot;
        alloc_funct  <= dec_funct;
        alloc_tag    <= rob_tail;
        alloc_rd     <= dec_rd;
        alloc_index  <= issue_idx;
        alloc_src1   <= src1_next;
        alloc_src2   <= src2_next;
      end
    end
  end

  // ROB occupancy and tail pointer. A flush empties the ROB; the
  // instruction index keeps counting across flushes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rob_count <= '0;
      rob_tail  <= '0;
      issue_idx <= '0;
    end else begin
      if (accept) begin
        issue_idx <= issue_idx + IDX_W'(1);
      end
      if (flush) begin
        rob_count <= '0;
        rob_tail  <= '0;
      end else begin
        if (accept) begin
          rob_tail <= (rob_tail == TAG_W'(ROB_DEPTH - 1)) ? '0
                                                           : rob_tail + TAG_W'(1);
        end
        unique case ({accept, commit_valid})
          2'b10:   rob_count <= rob_count + CNT_W'(1);
          2'b01:   rob_count <= rob_count - CNT_W'(1);
          default: rob_count <= rob_count;
        endcase
      end
    end
  end

endmodule
